// File: rtl/hs_link.sv
// hs_link: registered request/acknowledge link with a source half and a sink half.
// The source carries its own transfer counter as payload. It supports four-phase
// (return-to-zero) or two-phase (toggle) signalling. It counts completed transfers
// and keeps a sticky protocol-violation flag.
//
// Parameters:
//   WIDTH     payload / counter width (>= 1)
//   ACK_DELAY extra cycles the sink waits before acknowledging (0..15)
//   TWO_PHASE 0 = four-phase, 1 = two-phase
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en                 source may start new transfers while high
//   req_o, data_o      source request and payload
//   ack_i              acknowledge seen by the source
//   req_i, data_i      request and payload seen by the sink
//   ack_o              sink acknowledge
//   rx_data, rx_valid  last captured payload, one-cycle pulse on update
//   done_count         completed source transfers (wraps)
//   busy               source has an open transfer
//   err                sticky protocol-violation flag
module hs_link #(
  parameter int WIDTH     = 8,
  parameter int ACK_DELAY = 0,
  parameter bit TWO_PHASE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] done_count,
  output logic             busy,
  output logic             err
);

  // In two-phase mode SRC_WAIT_HI doubles as the single WAIT state.
  typedef enum logic [1:0] {SRC_IDLE, SRC_WAIT_HI, SRC_WAIT_LO} src_state_t;
  typedef enum logic [1:0] {SNK_IDLE, SNK_DLY, SNK_HOLD} snk_state_t;

  // The sink answers directly from IDLE when there is no delay, so the counter
  // is loaded with one less than the delay to keep ack at edge 2+ACK_DELAY.
  localparam logic [3:0] DLY_LOAD = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

  src_state_t       src_state, src_next;
  logic             req_q, req_next;
  logic [WIDTH-1:0] xfer_cnt, xfer_next;
  logic             ack_prev;
  logic             src_err;

  snk_state_t       snk_state, snk_next;
  logic             ack_q, ack_next;
  logic [3:0]       dly_cnt, dly_next;
  logic [WIDTH-1:0] cap_q, cap_next;
  logic [WIDTH-1:0] rx_data_q, rx_data_next;
  logic             rx_valid_q, rx_valid_next;
  logic             snk_err;
  logic             snk_trig;
  logic             ack_answer;
  logic             err_q;

  // Source: the payload counter doubles as the completion counter.
  // A completion and a fresh request may share the same edge.
  always_comb begin
    src_next  = src_state;
    req_next  = req_q;
    xfer_next = xfer_cnt;
    src_err   = 1'b0;
    if (TWO_PHASE) begin
      // An ack change is only expected while ack and req disagree.
      src_err = (ack_i != ack_prev) && (ack_prev == req_q);
      case (src_state)
        SRC_IDLE: begin
          if (en) begin
            req_next = ~req_q;
            src_next = SRC_WAIT_HI;
          end
        end
        SRC_WAIT_HI: begin
          if (ack_i == req_q) begin
            xfer_next = xfer_cnt + WIDTH'(1);
            if (en) req_next = ~req_q;
            else    src_next = SRC_IDLE;
          end
        end
        default: src_next = SRC_IDLE;
      endcase
    end else begin
      src_err = (ack_i && !ack_prev && (src_state != SRC_WAIT_HI)) ||
                (!ack_i && ack_prev && (src_state != SRC_WAIT_LO));
      case (src_state)
        SRC_IDLE: begin
          if (en) begin
            req_next = 1'b1;
            src_next = SRC_WAIT_HI;
          end
        end
        SRC_WAIT_HI: begin
          if (ack_i) begin
            req_next = 1'b0;
            src_next = SRC_WAIT_LO;
          end
        end
        SRC_WAIT_LO: begin
          if (!ack_i) begin
            xfer_next = xfer_cnt + WIDTH'(1);
            if (en) begin
              req_next = 1'b1;
              src_next = SRC_WAIT_HI;
            end else begin
              src_next = SRC_IDLE;
            end
          end
        end
        default: src_next = SRC_IDLE;
      endcase
    end
  end

  assign snk_trig   = TWO_PHASE ? (req_i != ack_q) : req_i;
  assign ack_answer = TWO_PHASE ? ~ack_q : 1'b1;

  // Sink: capture on request, optionally wait, then answer.
  // Four-phase holds the ack until the request returns to zero.
  always_comb begin
    snk_next      = snk_state;
    ack_next      = ack_q;
    dly_next      = dly_cnt;
    cap_next      = cap_q;
    rx_data_next  = rx_data_q;
    rx_valid_next = 1'b0;
    snk_err       = 1'b0;
    case (snk_state)
      SNK_IDLE: begin
        if (snk_trig) begin
          if (ACK_DELAY == 0) begin
            ack_next      = ack_answer;
            rx_data_next  = data_i;
            rx_valid_next = 1'b1;
            snk_next      = TWO_PHASE ? SNK_IDLE : SNK_HOLD;
          end else begin
            cap_next = data_i;
            dly_next = DLY_LOAD;
            snk_next = SNK_DLY;
          end
        end
      end
      SNK_DLY: begin
        // Four-phase request must stay up until it has been acknowledged.
        if (!TWO_PHASE && !req_i) snk_err = 1'b1;
        if (dly_cnt == 4'd0) begin
          ack_next      = ack_answer;
          rx_data_next  = cap_q;
          rx_valid_next = 1'b1;
          snk_next      = TWO_PHASE ? SNK_IDLE : SNK_HOLD;
        end else begin
          dly_next = dly_cnt - 4'd1;
        end
      end
      SNK_HOLD: begin
        if (!req_i) begin
          ack_next = 1'b0;
          snk_next = SNK_IDLE;
        end
      end
      default: snk_next = SNK_IDLE;
    endcase
  end

  // All state registers; every output is driven from here, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_state  <= SRC_IDLE;
      req_q      <= 1'b0;
      xfer_cnt   <= '0;
      ack_prev   <= 1'b0;
      snk_state  <= SNK_IDLE;
      ack_q      <= 1'b0;
      dly_cnt    <= 4'd0;
      cap_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      src_state  <= src_next;
      req_q      <= req_next;
      xfer_cnt   <= xfer_next;
      ack_prev   <= ack_i;
      snk_state  <= snk_next;
      ack_q      <= ack_next;
      dly_cnt    <= dly_next;
      cap_q      <= cap_next;
      rx_data_q  <= rx_data_next;
      rx_valid_q <= rx_valid_next;
      err_q      <= err_q | src_err | snk_err;
    end
  end

  assign req_o      = req_q;
  assign data_o     = xfer_cnt;
  assign done_count = xfer_cnt;
  assign busy       = (src_state != SRC_IDLE);
  assign ack_o      = ack_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_hs_link.sv
// tb_hs_link: three looped-back hs_link instances checked every cycle against
// a transfer-timeline model derived from the link's documented timing.
//   a: four-phase, WIDTH=8, ACK_DELAY=0 (ack_i can be overridden)
//   b: two-phase,  WIDTH=8, ACK_DELAY=3
//   c: four-phase, WIDTH=2, ACK_DELAY=1
module tb_hs_link;

  logic clk = 1'b0;
  logic rst_n;
  logic en_a, en_b, en_c;
  logic ovr, ovr_val;

  logic       req_a, ack_a, ack_in_a, rxv_a, busy_a, err_a;
  logic [7:0] data_a, rxd_a, done_a;
  logic       req_b, ack_b, rxv_b, busy_b, err_b;
  logic [7:0] data_b, rxd_b, done_b;
  logic       req_c, ack_c, rxv_c, busy_c, err_c;
  logic [1:0] data_c, rxd_c, done_c;

  int total = 0;
  int bad   = 0;

  // Timeline model: a transfer starts at t=0, the sink answers at t=1+D and
  // the transfer completes at t=period, where a new one may start at once.
  int pd[3]   = '{0, 3, 1};
  int two[3]  = '{0, 1, 0};
  int msk[3]  = '{255, 255, 3};
  int m_busy[3], m_t[3], m_cnt[3], m_tog[3], m_rxv[3], m_rxd[3], exp_err[3];

  always #5 clk = ~clk;

  assign ack_in_a = ovr ? ovr_val : ack_a;

  hs_link #(.WIDTH(8), .ACK_DELAY(0), .TWO_PHASE(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .req_o(req_a), .data_o(data_a),
    .ack_i(ack_in_a), .req_i(req_a), .data_i(data_a), .ack_o(ack_a),
    .rx_data(rxd_a), .rx_valid(rxv_a), .done_count(done_a), .busy(busy_a), .err(err_a));

  hs_link #(.WIDTH(8), .ACK_DELAY(3), .TWO_PHASE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .req_o(req_b), .data_o(data_b),
    .ack_i(ack_b), .req_i(req_b), .data_i(data_b), .ack_o(ack_b),
    .rx_data(rxd_b), .rx_valid(rxv_b), .done_count(done_b), .busy(busy_b), .err(err_b));

  hs_link #(.WIDTH(2), .ACK_DELAY(1), .TWO_PHASE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .req_o(req_c), .data_o(data_c),
    .ack_i(ack_c), .req_i(req_c), .data_i(data_c), .ack_o(ack_c),
    .rx_data(rxd_c), .rx_valid(rxv_c), .done_count(done_c), .busy(busy_c), .err(err_c));

  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModels();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_tog[i] = 0;
      m_rxv[i] = 0;  m_rxd[i] = 0; exp_err[i] = 0;
    end
  endtask

  task automatic stepModel(input int i, input bit e);
    int p;
    p = two[i] ? 2 + pd[i] : 4 + pd[i];
    m_rxv[i] = 0;
    if (m_busy[i] != 0) begin
      m_t[i]++;
      if (m_t[i] == 1 + pd[i]) begin
        m_rxv[i] = 1;
        m_rxd[i] = m_cnt[i] & msk[i];
      end
      if (m_t[i] == p) begin
        m_cnt[i]++;
        if (e) begin
          m_t[i] = 0;
          m_tog[i] ^= 1;
        end else begin
          m_busy[i] = 0;
        end
      end
    end else if (e) begin
      m_busy[i] = 1;
      m_t[i] = 0;
      m_tog[i] ^= 1;
    end
  endtask

  function automatic int expReq(input int i);
    if (two[i] != 0) return m_tog[i];
    return (m_busy[i] != 0 && m_t[i] < 2 + pd[i]) ? 1 : 0;
  endfunction

  function automatic int expAck(input int i);
    if (two[i] != 0) return (m_busy[i] != 0 && m_t[i] < 1 + pd[i]) ? (m_tog[i] ^ 1) : m_tog[i];
    return (m_busy[i] != 0 && m_t[i] >= 1 + pd[i] && m_t[i] <= 2 + pd[i]) ? 1 : 0;
  endfunction

  task automatic checkDut(input int i);
    int o_req, o_ack, o_data, o_done, o_rxd, o_rxv, o_busy, o_err;
    string n;
    case (i)
      0: begin
        o_req = req_a; o_ack = ack_a; o_data = data_a; o_done = done_a;
        o_rxd = rxd_a; o_rxv = rxv_a; o_busy = busy_a; o_err = err_a; n = "a";
      end
      1: begin
        o_req = req_b; o_ack = ack_b; o_data = data_b; o_done = done_b;
        o_rxd = rxd_b; o_rxv = rxv_b; o_busy = busy_b; o_err = err_b; n = "b";
      end
      default: begin
        o_req = req_c; o_ack = ack_c; o_data = data_c; o_done = done_c;
        o_rxd = rxd_c; o_rxv = rxv_c; o_busy = busy_c; o_err = err_c; n = "c";
      end
    endcase
    checkOutput({n, ".req"},      o_req,  expReq(i));
    checkOutput({n, ".ack"},      o_ack,  expAck(i));
    checkOutput({n, ".data"},     o_data, m_cnt[i] & msk[i]);
    checkOutput({n, ".done"},     o_done, m_cnt[i] & msk[i]);
    checkOutput({n, ".rx_data"},  o_rxd,  m_rxd[i]);
    checkOutput({n, ".rx_valid"}, o_rxv,  m_rxv[i]);
    checkOutput({n, ".busy"},     o_busy, m_busy[i]);
    checkOutput({n, ".err"},      o_err,  exp_err[i]);
  endtask

  // One clock: advance the model with the enables sampled at the edge,
  // then compare all three links on the falling edge.
  task automatic cycle();
    @(posedge clk);
    stepModel(0, en_a);
    stepModel(1, en_b);
    stepModel(2, en_c);
    @(negedge clk);
    for (int i = 0; i < 3; i++) checkDut(i);
  endtask

  // Randomly flip each enable with a low probability so that bursts,
  // single transfers and drops mid-transfer all occur.
  task automatic applyStimulus(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      if ($urandom_range(0, 7) == 0) en_a = ~en_a;
      if ($urandom_range(0, 7) == 0) en_b = ~en_b;
      if ($urandom_range(0, 7) == 0) en_c = ~en_c;
      cycle();
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    ovr = 1'b0; ovr_val = 1'b0;
    resetModels();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) checkDut(i);
    rst_n = 1'b1;

    // Sustained traffic from reset for 40 cycles, then let everything drain.
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    repeat (40) cycle();
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (12) cycle();
    checkOutput("a.done_after_40", done_a, 10);
    checkOutput("b.done_after_40", done_b, 8);

    applyStimulus(500);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (12) cycle();

    // Spurious ack while link a sits idle: err must rise and stick.
    ovr_val = 1'b1; ovr = 1'b1;
    exp_err[0] = 1;
    repeat (3) cycle();
    ovr = 1'b0; ovr_val = 1'b0;
    repeat (3) cycle();

    // Asynchronous reset while link a holds ack high.
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (ack_a) found = 1'b1;
    end
    checkOutput("a.ack_seen_before_reset", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 resetModels();
    for (int i = 0; i < 3; i++) checkDut(i);
    @(negedge clk);
    rst_n = 1'b1;

    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (rxv_a) begin
        found = 1'b1;
        checkOutput("a.first_data_after_reset", rxd_a, 0);
      end
    end
    checkOutput("a.pulse_after_reset", int'(found), 1);

    applyStimulus(200);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (12) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hs_link.md
# hs_link

Clocked, parametrised request/acknowledge link with a source half and a sink half. Both ends are registered, so the circular A→B→A dependency resolves at most once per clock edge and can never loop within a single time step. It supports four-phase (return-to-zero) or two-phase (toggle) signalling and carries a WIDTH-bit transfer counter as payload. It also counts completed transfers and flags protocol violations. Used standalone, or in loopback (req_o→req_i, data_o→data_i, ack_o→ack_i) as the reference handshake for later pipeline stages.

## Interface
- WIDTH, 8: payload and counter width (≥1)
- ACK_DELAY, 0: extra cycles the sink waits before answering a request (0..15)
- TWO_PHASE, 0: 0 = four-phase, 1 = two-phase; static
- clk  in  1  single clock; all state updates on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  source may start new transfers while high
- req_o  out  1  source request
- data_o  out  WIDTH  source payload; stable while a transfer is open
- ack_i  in  1  acknowledge seen by source
- req_i  in  1  request seen by sink
- data_i  in  WIDTH  payload seen by sink
- ack_o  out  1  sink acknowledge
- rx_data  out  WIDTH  last payload captured by sink
- rx_valid  out  1  one-cycle pulse when rx_data updates
- done_count  out  WIDTH  completed source transfers, wraps 2^WIDTH−1→0
- busy  out  1  source has an open transfer
- err  out  1  sticky protocol-violation flag

## Operation
- Reset (asynchronous, immediate, including mid-transfer): every output is 0, both FSMs are in IDLE, and the delay counter is 0.
- Payload: data_o is the source's transfer counter. It starts at 0 and increments by 1 (mod 2^WIDTH) on each completion, so data_o == done_count whenever busy is 0.
- Source FSM, four-phase:
  - IDLE: if en, set req_o=1 and go to WAIT_HI.
  - WAIT_HI: when ack_i=1, set req_o=0 and go to WAIT_LO.
  - WAIT_LO: when ack_i=0, increment done_count and data_o. If en, set req_o=1 and go to WAIT_HI (back-to-back); otherwise go to IDLE.
- Source FSM, two-phase:
  - IDLE: if en, toggle req_o and go to WAIT.
  - WAIT: when ack_i==req_o, increment done_count and data_o. If en, toggle req_o again and stay in WAIT; otherwise go to IDLE.
- Deasserting en never aborts an open transfer; it only suppresses the next one.
- busy=1 in every source state except IDLE.
- Sink FSM, four-phase:
  - IDLE: on req_i=1, capture data_i and load the delay counter with ACK_DELAY; go to DLY.
  - DLY: when the counter is 0, set ack_o=1, rx_data=captured value, rx_valid=1 for one cycle; go to HOLD. Otherwise decrement the counter.
  - HOLD: when req_i=0, set ack_o=0 and go to IDLE.
- Sink FSM, two-phase: same sequence, but it triggers on req_i != ack_o and answers by toggling ack_o. It has no HOLD state and returns to IDLE after the toggle.
- err is set (and held until reset) when ack_i changes while the source is not waiting for that change:
  - four-phase: an ack_i rise outside WAIT_HI, or an ack_i fall outside WAIT_LO;
  - two-phase: any ack_i change while ack_i==req_o.
  - Detection is edge-based, against ack_i registered on the previous cycle.
- The sink also sets err if req_i drops before ack_o is asserted (four-phase only).
- On err, both FSMs keep running.

## Timing
- Loopback timing, with edge 1 being the first edge where en=1 is sampled in IDLE:
  - Four-phase: req_o rises at edge 1. ack_o rises and rx_valid pulses at edge 2+ACK_DELAY. req_o falls at edge 3+ACK_DELAY. ack_o falls at edge 4+ACK_DELAY. done_count increments at edge 5+ACK_DELAY.
  - Two-phase: req_o toggles at edge 1. ack_o toggles and rx_valid pulses at edge 2+ACK_DELAY. done_count increments at edge 3+ACK_DELAY.
- Sustained throughput with en held high: one transfer per 4+ACK_DELAY cycles (four-phase) or 2+ACK_DELAY cycles (two-phase).
- Wrap-around: after 2^WIDTH transfers, data_o and done_count both read 0; no flag is raised.
- Simultaneous events: the completion edge and a new request happen in the same cycle (back-to-back); this is not a conflict.
- No combinational path from any input to any output.

## Test plan
- Four-phase loopback, WIDTH=8, ACK_DELAY=0, en held high for 40 cycles → rx_valid pulses carry rx_data 0,1,2,…; pulses are exactly 4 cycles apart; done_count=10 at the end; err=0.
- Two-phase loopback, ACK_DELAY=3, en high for 50 cycles → pulses exactly 5 cycles apart; ack_o toggles exactly once per transfer; err=0.
- WIDTH=2 loopback for 5 transfers → rx_data sequence 0,1,2,3,0; done_count=1 at the end.
- Drop en during WAIT_HI → that transfer completes (done_count +1) and req_o stays 0 afterwards; busy=0 within 4+ACK_DELAY cycles.
- Drive ack_i=1 while the source is in IDLE → err=1 on the next edge and stays 1; an rst_n pulse clears err.
- Assert rst_n=0 asynchronously while ack_o=1 → all outputs read 0 before the next clock edge; after release, the first transfer carries data 0.
